// File: rtl/pipe_skid_ctrl.sv
// rtl/pipe_skid_ctrl.sv - ready/valid skid-buffered pipeline stage controller
//
// Two enable-DFF register walls, MAIN and SKID, sequenced so the stage
// sustains one transfer per cycle under back-pressure while in_ready is a
// decode of registered state only (no combinational out_ready -> in_ready).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (0 = reset)
//   flush      synchronous squash of all held entries
//   in_valid   producer has payload
//   in_ready   stage can accept this cycle (from registered state)
//   in_data    producer payload, WIDTH bits
//   out_valid  MAIN holds valid payload
//   out_ready  consumer accepts this cycle
//   out_data   MAIN wall contents, WIDTH bits
//   occupancy  number of held entries, 0..2

module pipe_skid_ctrl #(
  parameter int WIDTH = 71
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Plain 2-bit encoding so the unused code 3 stays reachable for recovery.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic main_en;
  logic skid_en;
  logic main_from_skid;
  logic squash;
  logic in_fire;
  logic out_fire;

  assign squash   = !reset || flush;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = HALF;
      HALF: begin
        if (in_fire && !out_fire) begin
          state_d = FULL;
        end else if (!in_fire && out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL:    if (out_fire) state_d = HALF;
      default: state_d = EMPTY;
    endcase
    if (squash) state_d = EMPTY;
  end

  // Output logic: status decodes and wall enables.
  always_comb begin
    out_valid      = (state_q != EMPTY);
    in_ready       = (state_q != FULL);
    occupancy      = (state_q == FULL) ? 2'd2 : ((state_q == HALF) ? 2'd1 : 2'd0);
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: main_en = in_fire;
      HALF: begin
        // Draining and filling together keeps SKID untouched.
        main_en = in_fire && out_fire;
        skid_en = in_fire && !out_fire;
      end
      FULL: begin
        main_en        = out_fire;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
    // A squashed cycle must not disturb the walls.
    if (squash) begin
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  // Data walls: no reset, written only under controller enables.
  always_ff @(posedge clk) begin
    if (main_en) main_q <= main_from_skid ? skid_q : in_data;
    if (skid_en) skid_q <= in_data;
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_ctrl.sv
// tb/tb_pipe_skid_ctrl.sv - scoreboard bench for pipe_skid_ctrl
module tb_pipe_skid_ctrl;

  localparam int WIDTH = 71;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int n_chk  = 0;
  int n_fail = 0;
  int out_cnt = 0;

  logic [WIDTH-1:0] sb_q[$];

  pipe_skid_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT against the FIFO model, then apply the
  // transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    int  sz;
    logic m_in_ready;
    logic m_out_fire;
    sz = sb_q.size();
    chk("out_valid", WIDTH'(out_valid), WIDTH'(sz != 0));
    chk("in_ready", WIDTH'(in_ready), WIDTH'(sz < 2));
    chk("occupancy", WIDTH'(occupancy), WIDTH'(sz));
    if (sz != 0) chk("out_data", out_data, sb_q[0]);
    m_in_ready = (sz < 2);
    m_out_fire = (sz != 0) && out_ready;
    if (m_out_fire) begin
      void'(sb_q.pop_front());
      out_cnt++;
    end
    if (!reset || flush) begin
      sb_q.delete();
    end else if (in_valid && m_in_ready) begin
      sb_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the payload until the stage takes it; reports cycles spent.
  task automatic send(input logic [WIDTH-1:0] d, output int cycles);
    logic took;
    cycles = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    do begin
      took = in_ready;
      step();
      cycles++;
    end while (!took && cycles < 50);
    in_valid = 1'b0;
    chk("send_accept", WIDTH'(took), WIDTH'(1'b1));
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    int cyc;
    int total;
    int c0;
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = WIDTH'(1);
    out_ready = 1'b0;

    // Reset with a pending producer.
    step();
    chk("rst_out_valid_during", WIDTH'(out_valid), WIDTH'(1'b0));
    step();
    reset = 1'b1;
    in_valid = 1'b0;
    chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    chk("rst_occupancy", WIDTH'(occupancy), WIDTH'(0));

    // Pass-through, 1-cycle latency.
    out_ready = 1'b1;
    send(WIDTH'(71'h0AA), cyc);
    chk("pt_valid", WIDTH'(out_valid), WIDTH'(1'b1));
    chk("pt_data", out_data, WIDTH'(71'h0AA));
    chk("pt_occ1", WIDTH'(occupancy), WIDTH'(1));
    step();
    chk("pt_occ0", WIDTH'(occupancy), WIDTH'(0));

    // Streaming: one accept per cycle.
    c0 = out_cnt;
    total = 0;
    for (int i = 1; i <= 20; i++) begin
      send(WIDTH'(i), cyc);
      total += cyc;
    end
    step();
    step();
    chk("stream_cycles", WIDTH'(total), WIDTH'(20));
    chk("stream_count", WIDTH'(out_cnt - c0), WIDTH'(20));

    // Back-pressure: A in MAIN, B in SKID, C stalled.
    out_ready = 1'b0;
    send(WIDTH'(71'h7F), cyc);
    send(WIDTH'(71'h40_0000_0000_0000_0001), cyc);
    chk("bp_main", out_data, WIDTH'(71'h7F));
    chk("bp_occ", WIDTH'(occupancy), WIDTH'(2));
    chk("bp_in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
    in_valid = 1'b1;
    in_data = WIDTH'(71'h123);
    repeat (3) step();
    chk("bp_occ_hold", WIDTH'(occupancy), WIDTH'(2));
    out_ready = 1'b1;
    send(WIDTH'(71'h123), cyc);
    repeat (4) step();

    // Flush while FULL with a payload offered.
    out_ready = 1'b0;
    send(WIDTH'(71'h11), cyc);
    send(WIDTH'(71'h22), cyc);
    in_valid = 1'b1;
    in_data = WIDTH'(71'h55);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("fl_occ", WIDTH'(occupancy), WIDTH'(0));
    send(WIDTH'(71'h66), cyc);
    chk("fl_next_main", out_data, WIDTH'(71'h66));
    chk("fl_next_occ", WIDTH'(occupancy), WIDTH'(1));
    out_ready = 1'b1;
    repeat (2) step();

    // Reset mid-stream, then reset together with flush.
    out_ready = 1'b0;
    send(WIDTH'(71'h77), cyc);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rm_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    send(WIDTH'(71'h88), cyc);
    reset = 1'b0;
    flush = 1'b1;
    step();
    reset = 1'b1;
    flush = 1'b0;
    chk("rmf_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("rmf_occ", WIDTH'(occupancy), WIDTH'(0));

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = rnd();
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(39) == 0);
      reset     = ($urandom_range(59) != 0);
      step();
    end

    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_ctrl.md
Name: pipe_skid_ctrl

Overview:
- Ready/valid pipeline-stage controller for the out-of-order core's wide (71-bit) inter-stage registers.
- Owns two enable-DFF register walls, MAIN and SKID, and sequences their enables so the stage sustains one transfer per cycle under back-pressure with no combinational ready path from consumer to producer.
- Supports a pipeline flush from the ROB/branch unit.
- Sits between dispatch and reservation-station write, and is reused at other stage boundaries.

Parameters:
- WIDTH, 71, payload width in bits (width of each register wall).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  producer has payload.
- in_ready  output  1  stage can accept this cycle; driven from a register.
- in_data  input  WIDTH  producer payload.
- out_valid  output  1  MAIN holds valid payload.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  MAIN wall contents.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- State encoding: EMPTY (0 entries), HALF (MAIN valid), FULL (MAIN and SKID valid).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - occupancy = 0, 1 or 2 per state.
  - All three are functions of registered state only.
- Data walls have no reset. Only the controller's enable outputs decide writes. Payload bits are don't-care while the corresponding valid is 0.
- Transitions when reset=1 and flush=0:
  - EMPTY:
    - in_fire -> MAIN<=in_data, go to HALF.
    - Otherwise stay in EMPTY.
  - HALF:
    - in_fire & out_fire -> MAIN<=in_data, stay in HALF.
    - in_fire & !out_fire -> SKID<=in_data, go to FULL.
    - !in_fire & out_fire -> go to EMPTY.
    - Neither -> hold.
  - FULL (in_ready=0, so in_fire is impossible):
    - out_fire -> MAIN<=SKID, go to HALF.
    - Otherwise hold both walls unchanged.
- Ordering: strict FIFO. Payloads leave in acceptance order and are never duplicated.
- Latency: a payload accepted at edge N is visible on out_data with out_valid=1 in the cycle after edge N (1-cycle latency).
- Throughput: with out_ready held at 1, one transfer per cycle indefinitely and SKID is never written.
- flush=1 (reset=1):
  - Next state is EMPTY regardless of in_valid or out_ready.
  - A payload presented with in_fire in the flush cycle is discarded. The producer must treat it as squashed.
  - An out_fire in the flush cycle is a completed transfer from the consumer's side.
  - No wall enables are asserted in the flush cycle.
- reset=0: same effect as flush, and it overrides flush. After the reset edge: out_valid=0, in_ready=1, occupancy=0.
- Reset or flush mid-operation in FULL drops both entries. The next accepted payload lands in MAIN, never SKID.
- Protocol rules:
  - Once out_valid=1, out_data and out_valid stay stable until out_fire, flush or reset.
  - in_valid may drop without a transfer.
  - The block must not assume producer stability.
- Illegal state encoding 3: next state is EMPTY.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=71'h1 -> out_valid=0, in_ready=1, occupancy=0 during and after reset.
- Pass-through: send 71'h0AA with out_ready=1 -> out_valid=1 and out_data=71'h0AA exactly one cycle later; occupancy 1 then 0.
- Streaming: send 1,2,3,...,20 back-to-back with out_ready=1 -> 20 outputs in order, one per cycle, in_ready never 0.
- Back-pressure: out_ready=0, send A=71'h7F, B=71'h40_0000_0000_0000_0001, C -> A in MAIN, B in SKID, occupancy=2, in_ready=0, C not accepted. Raise out_ready -> A, B, C delivered in order with no loss.
- Flush while FULL: state FULL, assert flush=1 with in_valid=1, in_data=71'h55 -> next cycle out_valid=0, occupancy=0, 71'h55 never appears. A following send of 71'h66 appears in MAIN.
- Reset mid-stream: reset=0 pulsed in HALF with out_ready=0 -> EMPTY next cycle; flush=1 together with reset=0 gives an identical result.
